latch_bank_loader: RTL and testbench
====================================

# latch_bank_loader

Write-side controller for a bank of level-sensitive D-latch words. Accepts (address, data) write requests over a valid/ready handshake. Drives the shared data bus and one-hot word enables through three timed phases: setup, enable pulse, hold. This guarantees every latch sees stable data before it opens and after it closes. It sits between the synchronous datapath and any latch-based storage array.

## Interface
Parameters:
- WIDTH, 8, bits per latch word
- DEPTH, 4, number of latch words (≥1, need not be a power of 2)
- SETUP_CYC, 2, cycles data is stable with enables low before the pulse (≥1)
- PULSE_CYC, 3, cycles the selected enable is high (≥1)
- HOLD_CYC, 1, cycles data stays stable after the enable falls (≥1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  write request present
- req_ready  out  1  loader idle, can accept
- req_addr  in  AW  word index, AW = max(1, $clog2(DEPTH))
- req_data  in  WIDTH  word to store
- lat_d  out  WIDTH  shared data bus to all latch words
- lat_en  out  DEPTH  one-hot word enables; at most one bit set
- busy  out  1  high from accept until done
- done  out  1  one-cycle pulse at write completion
- err  out  1  valid with done; high when the address was out of range

## Operation
- FSM states: IDLE, SETUP, PULSE, HOLD. There is one phase down-counter.
- IDLE: req_ready=1. When req_valid is sampled high at a rising edge:
  - capture addr and data into registers;
  - load the counter with SETUP_CYC-1;
  - go to SETUP.
- SETUP: lat_d = captured data, lat_en = 0. When the counter reaches 0, load PULSE_CYC-1 and go to PULSE.
- PULSE: lat_en[addr] = 1. When the counter reaches 0, load HOLD_CYC-1 and go to HOLD.
- HOLD: lat_en = 0, lat_d unchanged. When the counter reaches 0, go to IDLE, pulse done, and drive err.
- Out-of-range address (addr ≥ DEPTH): the full phase sequence still runs, but lat_en stays 0 and err=1 with done.
- req_ready is a function of state only (IDLE) and never depends on req_valid.
- req_data and req_addr are ignored outside the accept edge.
- lat_d holds the last written word while IDLE. It changes only on the edge after an accept.
- All outputs are registered except req_ready and busy, which are decoded from the state register.

## Timing
- Reset values: state IDLE, lat_d=0, lat_en=0, done=0, err=0, busy=0, req_ready=1.
- Asserting rst forces lat_en to 0 immediately, without waiting for a clock edge.
- Let the accept edge be E:
  - lat_d is valid after E;
  - lat_en is high after edge E+SETUP_CYC for exactly PULSE_CYC cycles;
  - done is high for the one cycle after edge E+SETUP_CYC+PULSE_CYC+HOLD_CYC.
- In the done cycle, req_ready=1. A request accepted there starts a new SETUP on the next edge, so back-to-back writes have no idle bubble.
- Reset mid-operation (any non-IDLE state):
  - the write is aborted with no done pulse;
  - the addressed latch word may hold partial data, and the initiator must rewrite it.
- The counter is sized as $clog2(max(SETUP_CYC, PULSE_CYC, HOLD_CYC)+1) bits. It never wraps, because it is reloaded at every phase change.

## Structure
- Package latch_bank_loader_pkg:
  - state enum typedef (IDLE, SETUP, PULSE, HOLD);
  - function computing the counter width from the three phase parameters.
- One sub-module, phase_counter: a loadable down-counter with a zero flag, parameterised by width.
- The FSM, capture registers and enable decode live in the top module.

## Test plan
Bench config: WIDTH=8, DEPTH=4, SETUP_CYC=2, PULSE_CYC=3, HOLD_CYC=1. A behavioral D-latch bank model is attached to lat_d/lat_en.
- Reset, then write addr=2, data=0xA5:
  - lat_d=0xA5 after E+1;
  - lat_en=4'b0100 after edges E+2..E+4;
  - done=1, err=0 after E+6;
  - bank word 2 = 0xA5, all other words unchanged.
- Back-to-back writes (1,0x3C) then (3,0xF0), with valid held:
  - second accept on the done edge of the first;
  - lat_en never has two bits set;
  - lat_d changes only after lat_en=0 for ≥1 cycle;
  - words 1 and 3 are correct.
- Valid held during busy, with req_data toggling each cycle:
  - req_ready=0 throughout;
  - exactly one accept;
  - lat_d stays at the captured value.
- DEPTH=3 build, write addr=3, data=0x55:
  - lat_en stays 3'b000 throughout;
  - done=1 with err=1 after E+6;
  - no latch word changes.
- Assert rst while lat_en=4'b0001:
  - lat_en drops to 0 before the next clk edge;
  - no done pulse;
  - req_ready=1 on release.
- Edge parameters SETUP_CYC=PULSE_CYC=HOLD_CYC=1:
  - lat_en high for exactly 1 cycle;
  - done after E+3.

Source files
------------

// File: rtl/latch_bank_loader_pkg.sv
// Shared types and helpers for the latch bank write controller.
package latch_bank_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD
  } state_t;

  // One counter covers all three phases, so size it for the longest phase.
  function automatic int cnt_width(input int setup_cyc, input int pulse_cyc, input int hold_cyc);
    int longest;
    longest = setup_cyc;
    if (pulse_cyc > longest) longest = pulse_cyc;
    if (hold_cyc > longest) longest = hold_cyc;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/latch_bank_loader_phase_counter.sv
// Loadable down-counter with a zero flag; it parks at zero instead of wrapping.
module phase_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/latch_bank_loader.sv
// Write-side controller for a latch word bank: setup, enable pulse and hold phases
// around every write so each latch sees stable data across its open window.
module latch_bank_loader
  import latch_bank_loader_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int DEPTH     = 4,
  parameter  int SETUP_CYC = 2,
  parameter  int PULSE_CYC = 3,
  parameter  int HOLD_CYC  = 1,
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AW-1:0]    req_addr,
  input  logic [WIDTH-1:0] req_data,
  output logic [WIDTH-1:0] lat_d,
  output logic [DEPTH-1:0] lat_en,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CW = cnt_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             cnt_load;
  logic [CW-1:0]    cnt_load_val;
  logic             cnt_zero;
  logic [AW-1:0]    addr_q;
  logic             addr_oor;
  logic [DEPTH-1:0] lat_en_nxt;
  logic             done_nxt;
  logic             err_nxt;

  assign accept = (state == IDLE) && req_valid;

  phase_counter #(.W(CW)) u_phase_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The counter is reloaded with the length of the phase being entered.
  always_comb begin
    state_nxt    = state;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nxt    = SETUP;
          cnt_load     = 1'b1;
          cnt_load_val = CW'(SETUP_CYC - 1);
        end
      end
      SETUP: begin
        if (cnt_zero) begin
          state_nxt    = PULSE;
          cnt_load     = 1'b1;
          cnt_load_val = CW'(PULSE_CYC - 1);
        end
      end
      PULSE: begin
        if (cnt_zero) begin
          state_nxt    = HOLD;
          cnt_load     = 1'b1;
          cnt_load_val = CW'(HOLD_CYC - 1);
        end
      end
      HOLD: begin
        if (cnt_zero) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Enables are decoded from the next state so the registered lat_en lines up with PULSE.
  always_comb begin
    req_ready  = (state == IDLE);
    busy       = (state != IDLE);
    addr_oor   = 1'b1;
    lat_en_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr_q == AW'(i)) begin
        addr_oor      = 1'b0;
        lat_en_nxt[i] = (state_nxt == PULSE);
      end
    end
    done_nxt = (state == HOLD) && cnt_zero;
    err_nxt  = done_nxt && addr_oor;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      lat_d  <= '0;
      lat_en <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      lat_en <= lat_en_nxt;
      done   <= done_nxt;
      err    <= err_nxt;
      if (accept) begin
        addr_q <= req_addr;
        lat_d  <= req_data;
      end
    end
  end

endmodule

// File: tb/tb_latch_bank_loader.sv
// Bench for latch_bank_loader: a scoreboard of expected writes checked against
// behavioural latch banks on every done pulse, plus phase timing checks.
module tb_latch_bank_loader;

  typedef struct {
    logic [1:0] addr;
    logic [7:0] data;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int accepts     = 0;

  // Main instance: DEPTH=4, phases 2/3/1
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_addr;
  logic [7:0] req_data;
  logic [7:0] lat_d;
  logic [3:0] lat_en;
  logic       busy;
  logic       done;
  logic       err;

  // DEPTH=3 instance for the out-of-range case
  logic       d3_valid;
  logic       d3_ready;
  logic [1:0] d3_addr;
  logic [7:0] d3_data;
  logic [7:0] d3_lat_d;
  logic [2:0] d3_lat_en;
  logic       d3_busy;
  logic       d3_done;
  logic       d3_err;

  // Minimum phase lengths instance
  logic       e1_valid;
  logic       e1_ready;
  logic [1:0] e1_addr;
  logic [7:0] e1_data;
  logic [7:0] e1_lat_d;
  logic [3:0] e1_lat_en;
  logic       e1_busy;
  logic       e1_done;
  logic       e1_err;

  latch_bank_loader #(
    .WIDTH(8), .DEPTH(4), .SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(1)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .lat_d(lat_d), .lat_en(lat_en),
    .busy(busy), .done(done), .err(err)
  );

  latch_bank_loader #(
    .WIDTH(8), .DEPTH(3), .SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(1)
  ) dut_d3 (
    .clk(clk), .rst(rst), .req_valid(d3_valid), .req_ready(d3_ready),
    .req_addr(d3_addr), .req_data(d3_data), .lat_d(d3_lat_d), .lat_en(d3_lat_en),
    .busy(d3_busy), .done(d3_done), .err(d3_err)
  );

  latch_bank_loader #(
    .WIDTH(8), .DEPTH(4), .SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1)
  ) dut_e1 (
    .clk(clk), .rst(rst), .req_valid(e1_valid), .req_ready(e1_ready),
    .req_addr(e1_addr), .req_data(e1_data), .lat_d(e1_lat_d), .lat_en(e1_lat_en),
    .busy(e1_busy), .done(e1_done), .err(e1_err)
  );

  // Behavioural D-latch banks with distinct power-up contents
  logic [7:0] bank [4]       = '{8'hE0, 8'hE1, 8'hE2, 8'hE3};
  logic [7:0] bank3 [3]      = '{8'hC0, 8'hC1, 8'hC2};
  logic [7:0] bank3_init [3] = '{8'hC0, 8'hC1, 8'hC2};

  always @(lat_en or lat_d) begin
    for (int i = 0; i < 4; i++) begin
      if (lat_en[i]) bank[i] = lat_d;
    end
  end

  always @(d3_lat_en or d3_lat_d) begin
    for (int i = 0; i < 3; i++) begin
      if (d3_lat_en[i]) bank3[i] = d3_lat_d;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (req_valid && req_ready) accepts <= accepts + 1;
  end

  exp_t sb[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one request, waits (bounded) for it to be accepted and records the expectation.
  task automatic applyStimulus(input logic [1:0] a, input logic [7:0] d, input bit keep_valid,
                               output int acc_cyc);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    acc_cyc = cyc;
    if (n >= 50) checkOutput("ready_timeout", 32'(0), 32'(1));
    else sb.push_back('{addr: a, data: d, err: 1'b0});
    #1;
    if (!keep_valid) req_valid = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) checkOutput("done_timeout", 32'(0), 32'(1));
  endtask

  // Scoreboard monitor: pops on every done, checks bank contents and bus discipline.
  logic [7:0] exp_bank [4] = '{8'hE0, 8'hE1, 8'hE2, 8'hE3};
  logic [7:0] prev_d  = 8'h00;
  logic [3:0] prev_en = 4'h0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (lat_en != 4'h0) checkOutput("en_onehot", 32'($countones(lat_en)), 32'(1));
      if (lat_d != prev_d) checkOutput("d_change_en_closed", 32'({prev_en, lat_en}), 32'(0));
      if (done) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", 32'(1), 32'(0));
        end else begin
          e = sb.pop_front();
          checkOutput("done_err", 32'(err), 32'(e.err));
          if (!e.err) exp_bank[e.addr] = e.data;
          for (int i = 0; i < 4; i++)
            checkOutput($sformatf("bank%0d", i), 32'(bank[i]), 32'(exp_bank[i]));
        end
      end
    end
    prev_d  = lat_d;
    prev_en = lat_en;
  end

  initial begin
    int a1;
    int a2;
    int acc0;
    req_valid = 1'b0; req_addr = '0; req_data = '0;
    d3_valid  = 1'b0; d3_addr  = '0; d3_data  = '0;
    e1_valid  = 1'b0; e1_addr  = '0; e1_data  = '0;

    repeat (3) @(negedge clk);
    checkOutput("rst_lat_en_held", 32'(lat_en), 32'(0));
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_ready", 32'(req_ready), 32'(1));
    checkOutput("rst_busy", 32'(busy), 32'(0));
    checkOutput("rst_done", 32'(done), 32'(0));
    checkOutput("rst_err", 32'(err), 32'(0));
    checkOutput("rst_lat_d", 32'(lat_d), 32'(0));
    checkOutput("rst_lat_en", 32'(lat_en), 32'(0));

    // Single write with phase timing relative to the accept edge
    applyStimulus(2'd2, 8'hA5, 1'b0, a1);
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      checkOutput($sformatf("t1_en_e%0d", k), 32'(lat_en), (k >= 2 && k <= 4) ? 32'h4 : 32'h0);
      checkOutput($sformatf("t1_done_e%0d", k), 32'(done), (k == 6) ? 32'h1 : 32'h0);
      if (k == 0) checkOutput("t1_busy", 32'(busy), 32'(1));
      if (k == 1) checkOutput("t1_lat_d", 32'(lat_d), 32'hA5);
    end

    // Back-to-back writes with valid held across the done cycle
    applyStimulus(2'd1, 8'h3C, 1'b1, a1);
    applyStimulus(2'd3, 8'hF0, 1'b0, a2);
    checkOutput("b2b_accept_spacing", 32'(a2 - a1), 32'(7));
    waitDone(30);

    // Valid held through the whole write while data toggles
    acc0 = accepts;
    applyStimulus(2'd0, 8'h5A, 1'b1, a1);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("hold_ready_e%0d", k), 32'(req_ready), 32'(0));
      checkOutput($sformatf("hold_lat_d_e%0d", k), 32'(lat_d), 32'h5A);
      req_data = ~req_data;
    end
    @(negedge clk);
    checkOutput("hold_done", 32'(done), 32'(1));
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("hold_one_accept", 32'(accepts - acc0), 32'(1));
    checkOutput("hold_lat_d_after", 32'(lat_d), 32'h5A);

    // Reset in the middle of the enable pulse
    applyStimulus(2'd0, 8'h77, 1'b0, a1);
    repeat (3) @(negedge clk);
    checkOutput("abort_en_before", 32'(lat_en), 32'h1);
    rst = 1'b1;
    void'(sb.pop_back());
    #1;
    checkOutput("abort_en_async", 32'(lat_en), 32'(0));
    checkOutput("abort_done", 32'(done), 32'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("abort_ready", 32'(req_ready), 32'(1));
    repeat (6) @(negedge clk);
    checkOutput("abort_idle", 32'(busy), 32'(0));
    applyStimulus(2'd0, 8'h81, 1'b0, a1);
    waitDone(20);

    // Out-of-range address on the DEPTH=3 build
    checkOutput("d3_ready", 32'(d3_ready), 32'(1));
    d3_valid = 1'b1; d3_addr = 2'd3; d3_data = 8'h55;
    @(posedge clk);
    #1 d3_valid = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      checkOutput($sformatf("d3_en_e%0d", k), 32'(d3_lat_en), 32'(0));
      checkOutput($sformatf("d3_done_e%0d", k), 32'(d3_done), (k == 6) ? 32'h1 : 32'h0);
      if (k == 0) checkOutput("d3_busy", 32'(d3_busy), 32'(1));
      if (k == 1) checkOutput("d3_lat_d", 32'(d3_lat_d), 32'h55);
      if (k == 6) checkOutput("d3_err", 32'(d3_err), 32'(1));
    end
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("d3_bank%0d", i), 32'(bank3[i]), 32'(bank3_init[i]));

    // Single-cycle phases
    checkOutput("e1_ready", 32'(e1_ready), 32'(1));
    e1_valid = 1'b1; e1_addr = 2'd1; e1_data = 8'h99;
    @(posedge clk);
    #1 e1_valid = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("e1_en_e%0d", k), 32'(e1_lat_en), (k == 1) ? 32'h2 : 32'h0);
      checkOutput($sformatf("e1_done_e%0d", k), 32'(e1_done), (k == 3) ? 32'h1 : 32'h0);
      if (k == 0) checkOutput("e1_busy", 32'(e1_busy), 32'(1));
      if (k == 0) checkOutput("e1_lat_d", 32'(e1_lat_d), 32'h99);
      if (k == 3) checkOutput("e1_err", 32'(e1_err), 32'(0));
    end

    checkOutput("sb_drained", 32'(sb.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
